riscv_fetch_queue: RTL and testbench

RISCV_FETCH_QUEUE -- requirements
Module: riscv_fetch_queue

---
 rtl/riscv_fetch_queue_if.sv | 26 ++
 rtl/riscv_fetch_queue.sv | 99 +++++++++
 tb/tb_riscv_fetch_queue.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_fetch_queue_if.sv
// Fetch-queue handshake bundle: instruction-memory request/response channel
// plus the decode-side head-of-queue view and flush controls.
interface riscv_fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instrF;
    logic [31:0] pcF;
    logic [31:0] pcPlus4F;
    logic        validF;
    logic        stallF;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instrF, pcF, pcPlus4F, validF,
        input  imem_ready, imem_rvalid, imem_rdata, stallF, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instrF, pcF, pcPlus4F, validF,
        output imem_ready, imem_rvalid, imem_rdata, stallF, redirect, redirect_pc
    );
endinterface

// File: rtl/riscv_fetch_queue.sv
// Credit-based instruction fetch queue: issues in-order word fetches, buffers
// returned instructions with their PCs, and flushes/refetches on redirect.
module riscv_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    riscv_fetch_queue_if.master        fq
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = CW + 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_occ;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pc    [DEPTH];

    logic          w_acc;
    logic          w_rsp_drop;
    logic          w_rsp_live;
    logic          w_push;
    logic          w_pop;
    logic [SW-1:0] w_credit;
    logic [31:0]   w_redir_pc;

    // Every slot is charged from request acceptance until the entry is popped
    // or its response is discarded, so the queue can never overflow.
    assign w_credit      = SW'(r_occ) + SW'(r_out) + SW'(r_drop);
    assign fq.imem_req   = (r_state == RUN) && (w_credit < SW'(DEPTH));
    assign fq.imem_addr  = r_fetch_pc;
    assign w_acc         = fq.imem_req && fq.imem_ready;
    assign w_redir_pc    = fq.redirect_pc & 32'hFFFF_FFFC;

    // Responses retire stale requests first; a response with nothing
    // outstanding at all is spurious and ignored.
    assign w_rsp_drop    = fq.imem_rvalid && (r_drop != '0);
    assign w_rsp_live    = fq.imem_rvalid && (r_drop == '0) && (r_out != '0);
    assign w_push        = w_rsp_live && !fq.redirect;

    assign fq.validF     = (r_occ != '0);
    assign w_pop         = fq.validF && !fq.stallF && !fq.redirect;
    assign fq.instrF     = fq.validF ? r_instr[r_head] : 32'h0;
    assign fq.pcF        = fq.validF ? r_pc[r_head]    : 32'h0;
    assign fq.pcPlus4F   = fq.pcF + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_occ      <= '0;
            r_out      <= '0;
            r_drop     <= '0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            case (r_state)
                IDLE:    r_state <= RUN;
                default: r_state <= RUN;
            endcase
            if (fq.redirect) begin
                // Everything in flight, including a request accepted right now,
                // belongs to the old stream and must be discarded on return.
                r_fetch_pc <= w_redir_pc;
                r_resp_pc  <= w_redir_pc;
                r_occ      <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_out      <= '0;
                r_drop     <= r_drop + r_out + CW'(w_acc) - CW'(w_rsp_drop || w_rsp_live);
            end else begin
                if (w_acc)  r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_push) r_resp_pc  <= r_resp_pc + 32'd4;
                if (w_push) r_tail     <= r_tail + 1'b1;
                if (w_pop)  r_head     <= r_head + 1'b1;
                r_out  <= r_out + CW'(w_acc) - CW'(w_rsp_live);
                r_drop <= r_drop - CW'(w_rsp_drop);
                r_occ  <= r_occ + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_tail] <= fq.imem_rdata;
            r_pc[r_tail]    <= r_resp_pc;
        end
    end
endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue: zero-wait, stall, latency + redirect,
// full-queue redirect, ready backpressure and PC wrap.
module tb_riscv_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          acc_cnt = 0;
    logic [31:0] pa[$];
    int          pd[$];
    logic        p2_v = 1'b0;
    logic [31:0] p2_a = 32'h0;

    riscv_fetch_queue_if bus();
    riscv_fetch_queue_if bus2();

    riscv_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .fq(bus)
    );
    riscv_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .fq(bus2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: accepts at a negedge complete at the next posedge; the
    // response is presented lat cycles later with data = ~address.
    always @(negedge clk) begin
        if (rst) begin
            pa.delete();
            pd.delete();
            acc_cnt = 0;
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = 32'h0;
        end else begin
            bus.imem_rvalid = 1'b0;
            if (pd.size() > 0 && pd[0] == cyc) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = ~pa[0];
                void'(pa.pop_front());
                void'(pd.pop_front());
            end
            if (bus.imem_req && bus.imem_ready) begin
                pa.push_back(bus.imem_addr);
                pd.push_back(cyc + lat);
                acc_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            p2_v = 1'b0;
            bus2.imem_rvalid = 1'b0;
            bus2.imem_rdata  = 32'h0;
        end else begin
            bus2.imem_rvalid = p2_v;
            bus2.imem_rdata  = ~p2_a;
            p2_v = bus2.imem_req && bus2.imem_ready;
            p2_a = bus2.imem_addr;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1;
        bus.stallF = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_ready = 1'b1;
        lat = l;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(1);
        rst = 1'b1;
        tick();
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req got %b want 0", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr got %h want 0", bus.imem_addr); end
        n_cmp++; if (bus.validF !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b want 0", bus.validF); end
        n_cmp++; if (bus.instrF !== 32'h0 || bus.pcF !== 32'h0) begin n_bad++; $display("FAIL rst_head got %h/%h want 0/0", bus.instrF, bus.pcF); end
        n_cmp++; if (bus.pcPlus4F !== 32'h4) begin n_bad++; $display("FAIL rst_pc4 got %h want 4", bus.pcPlus4F); end
        n_cmp++; if (bus2.imem_addr !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL rst_addr2 got %h want fffffff8", bus2.imem_addr); end
        rst = 1'b0;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL idle_req got %b want 0", bus.imem_req); end
        tick();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL first_req got %b/%h want 1/0", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_zero_wait;
        do_reset(1);
        tick();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL zw_req got %b/%h want 1/0", bus.imem_req, bus.imem_addr); end
        tick();
        n_cmp++; if (bus.validF !== 1'b0) begin n_bad++; $display("FAIL zw_c2_valid got %b want 0", bus.validF); end
        tick();
        n_cmp++; if (bus.validF !== 1'b1 || bus.pcF !== 32'h0 || bus.instrF !== 32'hFFFF_FFFF || bus.pcPlus4F !== 32'h4)
            begin n_bad++; $display("FAIL zw_first got v%b pc %h ins %h p4 %h want v1 pc 0 ins ffffffff p4 4", bus.validF, bus.pcF, bus.instrF, bus.pcPlus4F); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_cmp++; if (bus.validF !== 1'b1 || bus.pcF !== 32'(4 * k))
                begin n_bad++; $display("FAIL zw_stream got v%b pc %h want v1 pc %h", bus.validF, bus.pcF, 32'(4 * k)); end
        end
    endtask

    task automatic test_stall;
        do_reset(1);
        bus.stallF = 1'b1;
        repeat (10) tick();
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL st_req got %b want 0", bus.imem_req); end
        n_cmp++; if (acc_cnt !== 4) begin n_bad++; $display("FAIL st_accepts got %0d want 4", acc_cnt); end
        bus.stallF = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (bus.validF !== 1'b1 || bus.pcF !== 32'(4 * k) || bus.instrF !== ~32'(4 * k))
                begin n_bad++; $display("FAIL st_drain got v%b pc %h ins %h want v1 pc %h", bus.validF, bus.pcF, bus.instrF, 32'(4 * k)); end
            tick();
        end
    endtask

    task automatic test_latency_redirect;
        logic [31:0] exp;
        int got;
        do_reset(3);
        repeat (4) tick();
        n_cmp++; if (bus.validF !== 1'b0) begin n_bad++; $display("FAIL lr_pre_valid got %b want 0", bus.validF); end
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h100;
        tick();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.imem_addr !== 32'h100) begin n_bad++; $display("FAIL lr_addr got %h want 100", bus.imem_addr); end
        exp = 32'h100;
        got = 0;
        for (int i = 0; i < 30 && got < 3; i++) begin
            if (bus.validF === 1'b1) begin
                n_cmp++; if (bus.pcF !== exp || bus.instrF !== ~exp)
                    begin n_bad++; $display("FAIL lr_stream got pc %h ins %h want pc %h ins %h", bus.pcF, bus.instrF, exp, ~exp); end
                exp = exp + 32'd4;
                got++;
            end
            tick();
        end
        n_cmp++; if (got !== 3) begin n_bad++; $display("FAIL lr_timeout got %0d entries want 3", got); end
    endtask

    task automatic test_redirect_full;
        bit seen;
        do_reset(1);
        bus.stallF = 1'b1;
        repeat (10) tick();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h203;
        tick();
        bus.redirect = 1'b0;
        n_cmp++; if (bus.validF !== 1'b0) begin n_bad++; $display("FAIL rf_valid got %b want 0", bus.validF); end
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin n_bad++; $display("FAIL rf_req got %b/%h want 1/200", bus.imem_req, bus.imem_addr); end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (bus.validF === 1'b1) seen = 1'b1;
        end
        n_cmp++; if (!seen || bus.pcF !== 32'h200 || bus.instrF !== ~32'h200)
            begin n_bad++; $display("FAIL rf_head got seen %b pc %h ins %h want pc 200", seen, bus.pcF, bus.instrF); end
        bus.stallF = 1'b0;
    endtask

    task automatic test_ready_low;
        logic [31:0] exp;
        logic [31:0] held;
        do_reset(1);
        exp = 32'h0;
        held = 32'h0;
        for (int i = 0; i < 25; i++) begin
            if (i == 4) begin
                bus.imem_ready = 1'b0;
                held = bus.imem_addr;
                n_cmp++; if (held !== 32'hC) begin n_bad++; $display("FAIL rl_held got %h want c", held); end
            end
            if (i == 9) bus.imem_ready = 1'b1;
            if (i > 4 && i < 9) begin
                n_cmp++; if (bus.imem_addr !== held || bus.imem_req !== 1'b1)
                    begin n_bad++; $display("FAIL rl_stable got %b/%h want 1/%h", bus.imem_req, bus.imem_addr, held); end
            end
            if (bus.validF === 1'b1) begin
                n_cmp++; if (bus.pcF !== exp || bus.instrF !== ~exp)
                    begin n_bad++; $display("FAIL rl_order got pc %h ins %h want pc %h", bus.pcF, bus.instrF, exp); end
                exp = exp + 32'd4;
            end
            tick();
        end
        n_cmp++; if (exp !== 32'h44) begin n_bad++; $display("FAIL rl_count got next pc %h want 44", exp); end
    endtask

    task automatic test_wrap;
        do_reset(1);
        repeat (3) tick();
        n_cmp++; if (bus2.validF !== 1'b1 || bus2.pcF !== 32'hFFFF_FFF8 || bus2.pcPlus4F !== 32'hFFFF_FFFC)
            begin n_bad++; $display("FAIL wr_0 got v%b pc %h p4 %h want fffffff8/fffffffc", bus2.validF, bus2.pcF, bus2.pcPlus4F); end
        tick();
        n_cmp++; if (bus2.validF !== 1'b1 || bus2.pcF !== 32'hFFFF_FFFC || bus2.pcPlus4F !== 32'h0)
            begin n_bad++; $display("FAIL wr_1 got v%b pc %h p4 %h want fffffffc/0", bus2.validF, bus2.pcF, bus2.pcPlus4F); end
        tick();
        n_cmp++; if (bus2.validF !== 1'b1 || bus2.pcF !== 32'h0 || bus2.pcPlus4F !== 32'h4 || bus2.instrF !== 32'hFFFF_FFFF)
            begin n_bad++; $display("FAIL wr_2 got v%b pc %h p4 %h ins %h want 0/4", bus2.validF, bus2.pcF, bus2.pcPlus4F, bus2.instrF); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stallF = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.imem_ready = 1'b1;
        bus2.stallF = 1'b0;
        bus2.redirect = 1'b0;
        bus2.redirect_pc = 32'h0;
        bus2.imem_ready = 1'b1;
        test_reset();
        test_zero_wait();
        test_stall();
        test_latency_redirect();
        test_redirect_full();
        test_ready_low();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
